// File: rtl/button_pkg.sv
// Shared types and constants for the mechanical-button waveform generator.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } state_e;

    localparam logic        BUTTON_RELEASED    = 1'b1;
    localparam logic [15:0] LFSR16_TAPS        = 16'hB400;
    localparam int unsigned SETTLE_CYC_DEFAULT = 1000000;

    // Right-shifting Galois step; the shifted-out bit folds the taps back in.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR16_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that steps once per advance pulse and reloads seed on reset.
module lfsr16
    import button_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= seed;
        end else if (advance) begin
            state_q <= lfsr16_next(state_q);
        end
    end

    assign state = state_q;

endmodule

// File: rtl/button_bounce_gen.sv
// Turns press/release commands into a bouncing active-low button waveform with settle and done.
// Define BUTTON_BOUNCE_RANDOM_EN to add LFSR-driven jitter to each bounce segment.
module button_bounce_gen
    import button_pkg::*;
#(
    parameter int unsigned W                = 32,
    parameter int unsigned BOUNCE_MAX       = 8,
    parameter int unsigned BOUNCE_MIN_CYC   = 16,
    parameter int unsigned BOUNCE_SPAN_LOG2 = 8,
    parameter int unsigned SETTLE_CYC       = SETTLE_CYC_DEFAULT,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_press,
    input  logic [3:0] cmd_bounces,
    output logic       button,
    output logic       busy,
    output logic       done
);

    // Counters hold "cycles left minus one" so a zero count marks the event cycle.
    localparam logic [W-1:0] SettleLast = W'(SETTLE_CYC - 1);
    localparam logic [W-1:0] MinLast    = W'(BOUNCE_MIN_CYC - 1);

    state_e         state_q, state_d;
    logic           button_q, button_d;
    logic           ready_q, ready_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   remain_q, remain_d;
    logic [W-1:0]   bounce_n;
    logic [W-1:0]   seg_last;
    logic           target;

`ifdef BUTTON_BOUNCE_RANDOM_EN
    logic        seg_load;
    logic [15:0] lfsr_state;

    // A segment is loaded whenever BOUNCE is entered or re-armed after a toggle.
    assign seg_load = (state_d == BOUNCE) && ((state_q != BOUNCE) || (cnt_q == '0));

    lfsr16 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (seg_load),
        .seed    (LFSR_SEED),
        .state   (lfsr_state)
    );

    assign seg_last = MinLast + W'(lfsr_state[BOUNCE_SPAN_LOG2-1:0]);
`else
    assign seg_last = MinLast;
`endif

    assign target   = ~cmd_press;
    assign bounce_n = (W'(cmd_bounces) > W'(BOUNCE_MAX)) ? W'(BOUNCE_MAX) : W'(cmd_bounces);

    always_comb begin
        state_d  = state_q;
        button_d = button_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        remain_d = remain_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    if (button_q == target) begin
                        // Redundant command: settle from a virtual edge, line untouched.
                        state_d = SETTLE;
                        cnt_d   = SettleLast;
                    end else begin
                        button_d = target;
                        if (bounce_n == '0) begin
                            state_d = SETTLE;
                            cnt_d   = SettleLast;
                        end else begin
                            state_d  = BOUNCE;
                            cnt_d    = seg_last;
                            remain_d = bounce_n << 1;
                        end
                    end
                end
            end
            BOUNCE: begin
                if (cnt_q == '0) begin
                    button_d = ~button_q;
                    if (remain_q == W'(1)) begin
                        state_d  = SETTLE;
                        cnt_d    = SettleLast;
                        remain_d = '0;
                    end else begin
                        remain_d = remain_q - W'(1);
                        cnt_d    = seg_last;
                    end
                end else begin
                    cnt_d = cnt_q - W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                button_d = BUTTON_RELEASED;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
                cnt_d    = '0;
                remain_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            button_q <= BUTTON_RELEASED;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            button_q <= button_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            remain_q <= remain_d;
        end
    end

    assign cmd_ready = ready_q;
    assign button    = button_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_button_bounce_gen.sv
// Directed self-checking bench for button_bounce_gen with SETTLE_CYC=20, BOUNCE_MIN_CYC=4.
module tb_button_bounce_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_press = 1'b0;
    logic [3:0] cmd_bounces = 4'd0;
    logic       button;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int edges[$];
    int dones[$];
    logic prev_button = 1'b1;

    button_bounce_gen #(
        .W                (32),
        .BOUNCE_MAX       (8),
        .BOUNCE_MIN_CYC   (4),
        .BOUNCE_SPAN_LOG2 (3),
        .SETTLE_CYC       (20),
        .LFSR_SEED        (16'hACE1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_press   (cmd_press),
        .cmd_bounces (cmd_bounces),
        .button      (button),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Timestamp every button edge and done pulse by the cycle in which it is visible.
    always begin
        @(posedge clk);
        #2;
        if (button !== prev_button) edges.push_back(cyc);
        prev_button = button;
        if (done === 1'b1) dones.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic p, input logic [3:0] b, output int t);
        edges.delete();
        dones.delete();
        cmd_valid   = 1'b1;
        cmd_press   = p;
        cmd_bounces = b;
        t = cyc;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int at);
        logic seen;
        seen = 1'b0;
        at = -1;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (done === 1'b1) begin
                seen = 1'b1;
                at = cyc;
            end
        end
        check("done_within_budget", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int t;
        int at;
        int bad;
        int e2[5] = '{1, 5, 9, 13, 17};

        // Reset held for two cycles
        tick();
        tick();
        check("rst_button", {31'd0, button}, 32'd1);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        tick();

`ifdef BUTTON_BOUNCE_RANDOM_EN
        begin
            logic [15:0] s;
            int gap;
            issue(1'b1, 4'd4, t);
            wait_done(400, at);
            check("rnd_edges", edges.size(), 32'd9);
            s = 16'hACE1;
            for (int i = 0; i < 8 && i + 1 < edges.size(); i++) begin
                gap = edges[i+1] - edges[i];
                check("rnd_gap_range", {31'd0, (gap >= 4 && gap <= 11)}, 32'd1);
                check("rnd_gap_golden", gap, 32'(4 + int'(s[2:0])));
                s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
            end
            if (edges.size() > 0) check("rnd_done_at", at - edges[edges.size()-1], 32'd20);
            check("rnd_level", {31'd0, button}, 32'd0);
        end
`else
        // Press with two bounces
        issue(1'b1, 4'd2, t);
        check("p2_ready_low", {31'd0, cmd_ready}, 32'd0);
        check("p2_busy", {31'd0, busy}, 32'd1);
        wait_done(80, at);
        check("p2_done_at", at - t, 32'd37);
        check("p2_edge_count", edges.size(), 32'd5);
        for (int i = 0; i < 5 && i < edges.size(); i++) check("p2_edge_time", edges[i] - t, e2[i]);
        check("p2_level", {31'd0, button}, 32'd0);
        check("p2_done_ready", {31'd0, cmd_ready}, 32'd1);
        check("p2_done_busy", {31'd0, busy}, 32'd0);
        tick();
        tick();
        check("p2_single_done", dones.size(), 32'd1);
        check("p2_done_cleared", {31'd0, done}, 32'd0);

        // Redundant press while already pressed
        issue(1'b1, 4'd3, t);
        bad = 0;
        for (int k = 1; k <= 20; k++) begin
            if (cmd_ready !== 1'b0) bad++;
            if (k < 20) tick();
        end
        check("red_ready_low_cycles", bad, 32'd0);
        tick();
        check("red_done_at", {31'd0, done}, 32'd1);
        check("red_done_cycle", cyc - t, 32'd21);
        check("red_ready_back", {31'd0, cmd_ready}, 32'd1);
        check("red_no_edges", edges.size(), 32'd0);
        check("red_level", {31'd0, button}, 32'd0);
        tick();

        // Release with zero bounces
        issue(1'b0, 4'd0, t);
        wait_done(60, at);
        check("r0_done_at", at - t, 32'd21);
        check("r0_edge_count", edges.size(), 32'd1);
        if (edges.size() > 0) check("r0_edge_time", edges[0] - t, 32'd1);
        check("r0_level", {31'd0, button}, 32'd1);
        tick();

        // Clamped bounce count with cmd_valid held through busy
        edges.delete();
        dones.delete();
        cmd_valid   = 1'b1;
        cmd_press   = 1'b1;
        cmd_bounces = 4'd15;
        t = cyc;
        tick();
        cmd_press   = 1'b0;
        cmd_bounces = 4'd0;
        bad = 0;
        at = -1;
        for (int i = 0; i < 200 && at < 0; i++) begin
            if (done === 1'b1) at = cyc;
            else begin
                if (cmd_ready !== 1'b0) bad++;
                tick();
            end
        end
        check("cl_ready_held_low", bad, 32'd0);
        check("cl_done_at", at - t, 32'd85);
        check("cl_edge_count", edges.size(), 32'd17);
        if (edges.size() == 17) check("cl_last_edge", edges[16] - t, 32'd65);
        bad = 0;
        for (int i = 0; i + 1 < edges.size(); i++) if (edges[i+1] - edges[i] != 4) bad++;
        check("cl_gaps", bad, 32'd0);
        check("cl_level", {31'd0, button}, 32'd0);
        check("cl_ready_at_done", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("cl_second_accept", {31'd0, button}, 32'd1);
        check("cl_second_busy", {31'd0, busy}, 32'd1);
        wait_done(60, at);
        check("cl_second_done", at - t, 32'd106);
        tick();

        // Reset in the middle of a bounce burst
        issue(1'b1, 4'd3, t);
        repeat (6) tick();
        check("mr_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        check("mr_button", {31'd0, button}, 32'd1);
        check("mr_ready", {31'd0, cmd_ready}, 32'd1);
        check("mr_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        dones.delete();
        edges.delete();
        repeat (60) tick();
        check("mr_no_done", dones.size(), 32'd0);
        check("mr_no_edges", edges.size(), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
